decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Parametrised instruction queue plus registered decode stage, between fetch and execute in the RV32I pipeline.
- Buffers up to DEPTH {pc, instruction} pairs from fetch.
- Decodes the head entry into register indices, formatted immediate and control flags, then presents the result through a valid/ready output register.
- Supports flush for branch redirect. Successor to the static instruction-format typedefs: adds buffering, handshakes and illegal-instruction detection.

Parameters:
- XLEN, 32: datapath/pc/immediate width; 32 or 64; immediates sign-extend to XLEN.
- DEPTH, 4: queue entries; power of two, >=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all queued and output-staged instructions
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept
- in_pc  in  XLEN  pc of offered instruction
- in_instr  in  32  raw instruction
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  pc
- out_opcode  out  7  opcode field
- out_funct3  out  3  funct3
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_imm  out  XLEN  formatted, sign-extended immediate
- out_alt  out  1  funct7[5] for OP, or for OP-IMM SRxI (sub/sra select)
- out_we_rd  out  1  writes rd
- out_use_rs1, out_use_rs2  out  1 each  reads rs1/rs2
- out_illegal  out  1  instruction illegal
- count  out  $clog2(DEPTH+1)  queue occupancy

Behaviour:
- Reset (async, rst_n low): all outputs 0; queue empty; pointers 0. in_ready goes 1 from the first edge after release.
- in_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready.
- Push: in_valid && in_ready at the edge.
- Pop: head exists && (!out_valid || out_ready). The head is then decoded combinationally and loaded into the output register.
- Output register: holds while out_valid && !out_ready. Drops out_valid when consumed and the queue is empty.
- Latency: push at edge E0 into an empty queue with an empty output register gives out_valid from edge E1 onward (1 cycle, plus one-cycle queue write). Throughput is 1 instruction per cycle.
- Simultaneous push and pop: count unchanged. Push when full: blocked by in_ready. Pointers wrap modulo DEPTH.
- flush: priority over push/pop. Next edge gives count=0, pointers reset, out_valid=0. A push in the flush cycle is dropped.
- Immediate formats (XLEN sign-extend of msb):
  - I: instr[31:20]. Used by JALR, LOAD, OP-IMM.
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - U: {instr[31:12],12'b0}. Used by LUI, AUIPC.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - OP: imm = 0.
- we_rd: LUI, AUIPC, JAL, JALR, OP-IMM, OP, LOAD; forced 0 when illegal or rd==0 is irrelevant (rd 0 still we_rd=1).
- use_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- use_rs2: BRANCH, STORE, OP.
- Illegal when any of:
  - opcode not in {LUI, AUIPC, JAL, JALR, OP-IMM, OP, BRANCH, LOAD, STORE};
  - instr[1:0] != 2'b11;
  - JALR funct3 != 0;
  - BRANCH funct3 in {010, 011};
  - LOAD funct3 in {011, 110, 111};
  - STORE funct3 > 010;
  - OP funct7 not 0000000, or 0100000 with funct3 not ADD/SR;
  - OP-IMM SLLI with funct7 != 0;
  - OP-IMM SRxI with funct7 not in {0000000, 0100000}.
- Illegal instructions still flow through with out_illegal=1 and we_rd=use_rs1=use_rs2=0.

Optional Feature:
- DECODE_RV32M_EN defined: OP with funct7=0000001 is legal (all funct3) with we_rd, use_rs1, use_rs2 set, and out_muldiv (extra 1-bit output) = 1.
- Undefined: funct7=0000001 is illegal and the out_muldiv port is absent.

Decomposition:
- Shared package (existing instruction-type package) gains:
  - imm_fmt_t enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - decoded_t packed struct of all out_* decode fields;
  - constant MULDIV_F7 = 7'b0000001.
- Sub-module inst_decoder: purely combinational, instr[31:0] -> decoded_t, parametrised by XLEN. The queue and output register live in decode_queue.

Test Plan:
- Push 0xFFF00093 (addi x1,x0,-1), pc 0x100, out_ready=1 -> out_imm=0xFFFFFFFF, rd=1, rs1=0, we_rd=1, use_rs2=0, illegal=0, out_pc=0x100.
- Push 0xFE208EE3 (beq x1,x2,-4) -> imm=0xFFFFFFFC, rs1=1, rs2=2, we_rd=0, use_rs2=1. Push 0x00312423 (sw x3,8(x2)) -> imm=8, rs1=2, rs2=3.
- Push 0x123452B7 (lui x5) -> imm=0x12345000, rd=5. Hold out_ready=0 and push DEPTH+1 more -> count=DEPTH, in_ready=0, out_* stable. Release -> in-order drain, 1 per cycle.
- Push 0x023100B3 (mul x1,x2,x3) -> illegal=1 without macro; illegal=0, out_muldiv=1 with DECODE_RV32M_EN.
- Queue 3 entries with out_valid=1, assert flush together with in_valid -> next cycle count=0, out_valid=0, flushed-cycle push absent.
- Assert rst_n low mid-stream (async, between edges) -> out_valid, count, all outputs 0 immediately.

Source files
------------

// File: rtl/decode_queue_pkg.sv
//==============================================================================
// Module  : decode_queue_pkg
// Purpose : Shared RV32I instruction-type definitions: opcodes, immediate
//           formats, the decoded-instruction record and the immediate formatter.
//           DECODE_RV32M_EN adds the muldiv field to decoded_t.
// Revision: 1.0
//==============================================================================
`default_nettype none

package decode_queue_pkg;

    localparam int c_XLEN_MAX = 64;

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [6:0] MULDIV_F7 = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

    // imm is carried at the widest supported XLEN; bits above XLEN are zero.
    typedef struct packed {
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [c_XLEN_MAX-1:0] imm;
        logic                  alt;
        logic                  we_rd;
        logic                  use_rs1;
        logic                  use_rs2;
        logic                  illegal;
`ifdef DECODE_RV32M_EN
        logic                  muldiv;
`endif
    } decoded_t;

    // Returns the immediate sign-extended to 32 bits.
    function automatic logic [31:0] format_imm(input imm_fmt_t fmt, input logic [31:0] instr);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_queue_if.sv
//==============================================================================
// Module  : decode_queue_if
// Purpose : Fetch-side and execute-side handshake bundle of decode_queue.
//           DECODE_RV32M_EN adds out_muldiv.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface decode_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_pc;
    logic [31:0]        in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [6:0]         out_opcode;
    logic [2:0]         out_funct3;
    logic [4:0]         out_rd;
    logic [4:0]         out_rs1;
    logic [4:0]         out_rs2;
    logic [XLEN-1:0]    out_imm;
    logic               out_alt;
    logic               out_we_rd;
    logic               out_use_rs1;
    logic               out_use_rs2;
    logic               out_illegal;
`ifdef DECODE_RV32M_EN
    logic               out_muldiv;
`endif
    logic [c_CNT_W-1:0] count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_rd, out_rs1, out_rs2,
               out_imm, out_alt, out_we_rd, out_use_rs1, out_use_rs2, out_illegal,
`ifdef DECODE_RV32M_EN
               out_muldiv,
`endif
               count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_rd, out_rs1, out_rs2,
               out_imm, out_alt, out_we_rd, out_use_rs1, out_use_rs2, out_illegal,
`ifdef DECODE_RV32M_EN
               out_muldiv,
`endif
               count
    );

endinterface

`default_nettype wire

// File: rtl/decode_queue_inst_decoder.sv
//==============================================================================
// Module  : inst_decoder
// Purpose : Combinational RV32I decoder: raw instruction to decoded_t, with
//           illegal-instruction detection. DECODE_RV32M_EN accepts OP/M-ext.
// Revision: 1.0
//==============================================================================
`default_nettype none

module inst_decoder
    import decode_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] instr,
    output decoded_t    dec
);

    localparam logic [c_XLEN_MAX-1:0] c_IMM_MASK =
        (XLEN >= c_XLEN_MAX) ? {c_XLEN_MAX{1'b1}} : ((64'd1 << XLEN) - 64'd1);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    imm_fmt_t    w_fmt;
    logic        w_known;
    logic        w_bad;
    logic        w_wr;
    logic        w_r1;
    logic        w_r2;
    logic        w_md;
    logic        w_illegal;
    logic [31:0] w_imm32;

    always_comb begin
        w_opcode = instr[6:0];
        w_f3     = instr[14:12];
        w_f7     = instr[31:25];
        w_fmt    = IMM_NONE;
        w_known  = 1'b1;
        w_bad    = 1'b0;
        w_wr     = 1'b0;
        w_r1     = 1'b0;
        w_r2     = 1'b0;
        w_md     = 1'b0;

        case (w_opcode)
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_fmt = IMM_U;
                w_wr  = 1'b1;
            end
            c_OPC_JAL: begin
                w_fmt = IMM_J;
                w_wr  = 1'b1;
            end
            c_OPC_JALR: begin
                w_fmt = IMM_I;
                w_wr  = 1'b1;
                w_r1  = 1'b1;
                w_bad = (w_f3 != 3'b000);
            end
            c_OPC_BRANCH: begin
                w_fmt = IMM_B;
                w_r1  = 1'b1;
                w_r2  = 1'b1;
                w_bad = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            c_OPC_LOAD: begin
                w_fmt = IMM_I;
                w_wr  = 1'b1;
                w_r1  = 1'b1;
                w_bad = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            c_OPC_STORE: begin
                w_fmt = IMM_S;
                w_r1  = 1'b1;
                w_r2  = 1'b1;
                w_bad = (w_f3 > 3'b010);
            end
            c_OPC_OPIMM: begin
                w_fmt = IMM_I;
                w_wr  = 1'b1;
                w_r1  = 1'b1;
                // Shift-immediates reuse the upper immediate bits as funct7.
                if (w_f3 == 3'b001) begin
                    w_bad = (w_f7 != c_F7_BASE);
                end else if (w_f3 == 3'b101) begin
                    w_bad = (w_f7 != c_F7_BASE) && (w_f7 != c_F7_ALT);
                end
            end
            c_OPC_OP: begin
                w_fmt = IMM_NONE;
                w_wr  = 1'b1;
                w_r1  = 1'b1;
                w_r2  = 1'b1;
                if (w_f7 == c_F7_BASE) begin
                    w_bad = 1'b0;
                end else if (w_f7 == c_F7_ALT) begin
                    w_bad = (w_f3 != 3'b000) && (w_f3 != 3'b101);
`ifdef DECODE_RV32M_EN
                end else if (w_f7 == MULDIV_F7) begin
                    w_md = 1'b1;
`endif
                end else begin
                    w_bad = 1'b1;
                end
            end
            default: w_known = 1'b0;
        endcase

        w_illegal = !w_known || w_bad || (instr[1:0] != 2'b11);
        w_imm32   = format_imm(w_fmt, instr);

        dec         = '0;
        dec.opcode  = w_opcode;
        dec.funct3  = w_f3;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.imm     = {{(c_XLEN_MAX-32){w_imm32[31]}}, w_imm32} & c_IMM_MASK;
        dec.alt     = ((w_opcode == c_OPC_OP) && w_f7[5]) ||
                      ((w_opcode == c_OPC_OPIMM) && (w_f3 == 3'b101) && instr[30]);
        dec.we_rd   = w_wr && !w_illegal;
        dec.use_rs1 = w_r1 && !w_illegal;
        dec.use_rs2 = w_r2 && !w_illegal;
        dec.illegal = w_illegal;
`ifdef DECODE_RV32M_EN
        dec.muldiv  = w_md && !w_illegal;
`endif
    end

`ifndef DECODE_RV32M_EN
    logic w_md_unused;
    assign w_md_unused = w_md;
`endif

endmodule

`default_nettype wire

// File: rtl/decode_queue.sv
//==============================================================================
// Module  : decode_queue
// Purpose : DEPTH-entry {pc, instr} queue feeding a registered decode stage
//           with valid/ready output and flush. DECODE_RV32M_EN adds out_muldiv.
// Revision: 1.0
//==============================================================================
`default_nettype none

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    decode_queue_if.slave bus
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [XLEN-1:0]    r_pc_mem    [DEPTH];
    logic [31:0]        r_instr_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               r_in_ready;
    logic               w_push;
    logic               w_pop;
    logic               r_out_valid;
    logic [XLEN-1:0]    r_out_pc;
    decoded_t           r_out_dec;
    decoded_t           w_dec;

    assign w_push = bus.in_valid && r_in_ready;
    assign w_pop  = (r_count != '0) && (!r_out_valid || bus.out_ready);

    always_comb begin
        w_count_nxt = r_count;
        if (bus.flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !bus.flush) begin
            r_pc_mem[r_wr_ptr]    <= bus.in_pc;
            r_instr_mem[r_wr_ptr] <= bus.in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < c_DEPTH);
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    inst_decoder #(
        .XLEN (XLEN)
    ) u_dec (
        .instr (r_instr_mem[r_rd_ptr]),
        .dec   (w_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_dec   <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_pc_mem[r_rd_ptr];
            r_out_dec   <= w_dec;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.count       = r_count;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_out_pc;
    assign bus.out_opcode  = r_out_dec.opcode;
    assign bus.out_funct3  = r_out_dec.funct3;
    assign bus.out_rd      = r_out_dec.rd;
    assign bus.out_rs1     = r_out_dec.rs1;
    assign bus.out_rs2     = r_out_dec.rs2;
    assign bus.out_imm     = XLEN'(r_out_dec.imm);
    assign bus.out_alt     = r_out_dec.alt;
    assign bus.out_we_rd   = r_out_dec.we_rd;
    assign bus.out_use_rs1 = r_out_dec.use_rs1;
    assign bus.out_use_rs2 = r_out_dec.use_rs2;
    assign bus.out_illegal = r_out_dec.illegal;
`ifdef DECODE_RV32M_EN
    assign bus.out_muldiv  = r_out_dec.muldiv;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
//==============================================================================
// Module  : tb_decode_queue
// Purpose : Self-checking bench for decode_queue (table vectors + scoreboard,
//           backpressure, flush, async reset). Honours DECODE_RV32M_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [5:0]  flg;   // {alt, we_rd, use_rs1, use_rs2, illegal, muldiv}
    } vec_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [5:0]      flg;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic md_act;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    decode_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    decode_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef DECODE_RV32M_EN
    assign md_act = bus.out_muldiv;
`else
    assign md_act = 1'b0;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input vec_t v, input logic [XLEN-1:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = v.instr;
        e.imm   = v.imm;
        e.flg   = v.flg;
        return e;
    endfunction

    function automatic logic [127:0] exp_bundle(input exp_t e);
        return 128'({e.pc, e.instr[6:0], e.instr[14:12], e.instr[11:7], e.instr[19:15],
                     e.instr[24:20], e.imm, e.flg});
    endfunction

    // Handshake happens at the next posedge; compare while outputs are stable.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got pc %h expected none", bus.out_pc);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("decode pc=%h", mon_e.pc),
                      128'({bus.out_pc, bus.out_opcode, bus.out_funct3, bus.out_rd, bus.out_rs1,
                            bus.out_rs2, bus.out_imm, bus.out_alt, bus.out_we_rd, bus.out_use_rs1,
                            bus.out_use_rs2, bus.out_illegal, md_act}),
                      exp_bundle(mon_e));
            end
        end
    end

    task automatic push(input exp_t e);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_pc    = e.pc;
        bus.in_instr = e.instr;
        while (!bus.in_ready && t < 64) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!bus.in_ready) begin
            check("push_timeout", 128'(bus.in_ready), 128'(1));
            bus.in_valid = 1'b0;
        end else begin
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name, input int bound);
        int t = 0;
        while (sb.size() != 0 && t < bound) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;

        vecs.push_back('{32'hFFF00093, 32'hFFFFFFFF, 6'b011000}); // addi x1,x0,-1
        vecs.push_back('{32'hFE208EE3, 32'hFFFFFFFC, 6'b001100}); // beq x1,x2,-4
        vecs.push_back('{32'h00312423, 32'h00000008, 6'b001100}); // sw x3,8(x2)
        vecs.push_back('{32'h123452B7, 32'h12345000, 6'b010000}); // lui x5
`ifdef DECODE_RV32M_EN
        vecs.push_back('{32'h023100B3, 32'h00000000, 6'b011101}); // mul
`else
        vecs.push_back('{32'h023100B3, 32'h00000000, 6'b000010}); // mul
`endif
        vecs.push_back('{32'h40208033, 32'h00000000, 6'b111100}); // sub x0,x1,x2
        vecs.push_back('{32'h4020C033, 32'h00000000, 6'b100010}); // f7=0100000 xor
        vecs.push_back('{32'h4030D093, 32'h00000403, 6'b111000}); // srai x1,x1,3
        vecs.push_back('{32'h00008067, 32'h00000000, 6'b011000}); // jalr x0,0(x1)
        vecs.push_back('{32'h008000EF, 32'h00000008, 6'b010000}); // jal x1,+8
        vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 6'b000010}); // bad opcode
        vecs.push_back('{32'h00003003, 32'h00000000, 6'b000010}); // load f3=011
        vecs.push_back('{32'h00002083, 32'h00000000, 6'b011000}); // lw x1,0(x0)
        vecs.push_back('{32'h00000010, 32'h00000000, 6'b000010}); // instr[1:0]!=11
        vecs.push_back('{32'hFFFFF117, 32'hFFFFF000, 6'b010000}); // auipc x2
        vecs.push_back('{32'h02009093, 32'h00000020, 6'b000010}); // slli f7!=0

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 128'(bus.out_valid), 128'(0));
        check("reset_count", 128'(bus.count), 128'(0));
        check("reset_in_ready", 128'(bus.in_ready), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 128'(bus.in_ready), 128'(1));

        // Table vectors, back-to-back with the consumer always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            push(mk_exp(vecs[i], XLEN'(32'h100 + 4 * i)));
        end
        bus.in_valid = 1'b0;
        drain("drain_table", 20);
        check("count_idle", 128'(bus.count), 128'(0));

        // Backpressure: fill to DEPTH behind a held output
        bus.out_ready = 1'b0;
        push(mk_exp(vecs[3], XLEN'(32'h200)));
        for (int i = 0; i < DEPTH; i++) begin
            push(mk_exp(vecs[5 + i], XLEN'(32'h204 + 4 * i)));
        end
        bus.in_valid = 1'b1;
        bus.in_pc    = XLEN'(32'h300);
        bus.in_instr = vecs[9].instr;
        repeat (3) @(posedge clk);
        #1;
        check("full_count", 128'(bus.count), 128'(DEPTH));
        check("full_in_ready", 128'(bus.in_ready), 128'(0));
        check("held_out_valid", 128'(bus.out_valid), 128'(1));
        check("held_out_pc", 128'(bus.out_pc), 128'(32'h200));
        check("held_out_imm", 128'(bus.out_imm), 128'(32'h12345000));
        bus.out_ready = 1'b1;
        push(mk_exp(vecs[9], XLEN'(32'h300)));
        bus.in_valid = 1'b0;
        drain("drain_backpressure", DEPTH + 3);

        // Flush with three queued entries and a staged output
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(mk_exp(vecs[i], XLEN'(32'h400 + 4 * i)));
        end
        bus.in_valid = 1'b0;
        check("preflush_count", 128'(bus.count), 128'(3));
        check("preflush_out_valid", 128'(bus.out_valid), 128'(1));
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pc    = XLEN'(32'h500);
        bus.in_instr = vecs[12].instr;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        check("flush_count", 128'(bus.count), 128'(0));
        check("flush_out_valid", 128'(bus.out_valid), 128'(0));
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush_push_dropped", 128'(bus.out_valid), 128'(0));
        check("postflush_count", 128'(bus.count), 128'(0));
        push(mk_exp(vecs[0], XLEN'(32'h600)));
        bus.in_valid = 1'b0;
        drain("drain_postflush", 6);

        // Asynchronous reset between edges
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(mk_exp(vecs[13 + i], XLEN'(32'h700 + 4 * i)));
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("areset_out_valid", 128'(bus.out_valid), 128'(0));
        check("areset_count", 128'(bus.count), 128'(0));
        check("areset_in_ready", 128'(bus.in_ready), 128'(0));
        check("areset_outputs",
              128'({bus.out_pc, bus.out_imm, bus.out_rd, bus.out_we_rd, bus.out_illegal}),
              128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_areset", 128'(bus.in_ready), 128'(1));
        bus.out_ready = 1'b1;
        push(mk_exp(vecs[7], XLEN'(32'h800)));
        bus.in_valid = 1'b0;
        drain("drain_after_areset", 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
